// File: rtl/adex_spike_monitor.sv
// Spike monitor for the AdEx neuron core. It measures inter-spike intervals in update steps and buffers them
// in a FIFO that is read out MSB nibble first. It also reports the spike count of each programmable window.
module adex_spike_monitor #(
    parameter int unsigned ISI_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             step_valid,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             rd_req,
    output logic [3:0]       rd_nibble,
    output logic             rd_valid,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             overflow,
    output logic [CNT_W-1:0] rate_count,
    output logic             win_done
);

    localparam int unsigned NIB   = ISI_W / 4;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        R_IDLE,
        R_SEND
    } rd_state_t;

    // ISI and window state
    logic             first_seen;
    logic [ISI_W-1:0] isi_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;

    logic             spike_ev;
    logic             isi_push;
    logic [ISI_W-1:0] isi_inc;
    logic [CNT_W-1:0] spk_inc;
    logic             win_last;

    // FIFO state
    logic [ISI_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    fill;
    logic [PW-1:0]    fill_n;
    logic             pop;
    logic             push_ok;
    logic             pop_ok;
    logic [ISI_W-1:0] head;

    // Read FSM state
    rd_state_t        state, state_n;
    logic             rd_req_q;
    logic             rd_edge;
    logic [ISI_W-1:0] shreg, shreg_n;
    logic [IDX_W-1:0] nib_idx, nib_idx_n;
    logic [3:0]       rd_nibble_n;
    logic             rd_valid_n;

    assign spike_ev = step_valid & spike_in & enable;
    assign isi_push = spike_ev & first_seen;
    assign isi_inc  = (isi_cnt == '1) ? isi_cnt : isi_cnt + 1'b1;
    assign spk_inc  = (spike_ev && spk_cnt != '1) ? spk_cnt + 1'b1 : spk_cnt;
    // >= rather than == so that shrinking win_len mid-window cannot strand the counter
    assign win_last = (win_cnt >= WIN_W'(win_len - 1'b1));

    // ISI counter, window counter and rate reporting
    always_ff @(posedge clk) begin
        if (reset) begin
            first_seen <= 1'b0;
            isi_cnt    <= '0;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            rate_count <= '0;
            win_done   <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (!enable) begin
                first_seen <= 1'b0;
                isi_cnt    <= '0;
                win_cnt    <= '0;
                spk_cnt    <= '0;
            end else if (step_valid) begin
                if (spike_ev) begin
                    isi_cnt    <= ISI_W'(1);
                    first_seen <= 1'b1;
                end else begin
                    isi_cnt <= isi_inc;
                end

                if (win_len == '0) begin
                    win_cnt <= '0;
                    spk_cnt <= '0;
                end else if (win_last) begin
                    rate_count <= spk_inc;
                    win_done   <= 1'b1;
                    win_cnt    <= '0;
                    spk_cnt    <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    spk_cnt <= spk_inc;
                end
            end
        end
    end

    // FIFO occupancy; a push into a full FIFO is accepted only if a pop frees a slot this cycle
    assign fill    = PW'(wr_ptr - rd_ptr);
    assign pop_ok  = pop & ~fifo_empty;
    assign push_ok = isi_push & (~fifo_full | pop_ok);
    assign fill_n  = PW'(fill + PW'(push_ok) - PW'(pop_ok));
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= isi_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (isi_push && !push_ok) begin
                overflow <= 1'b1;
            end
            fifo_empty <= (fill_n == '0);
            fifo_full  <= (fill_n == PW'(FIFO_DEPTH));
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= R_IDLE;
            rd_req_q  <= 1'b0;
            shreg     <= '0;
            nib_idx   <= '0;
            rd_nibble <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            rd_req_q  <= rd_req;
            shreg     <= shreg_n;
            nib_idx   <= nib_idx_n;
            rd_nibble <= rd_nibble_n;
            rd_valid  <= rd_valid_n;
        end
    end

    assign rd_edge = rd_req & ~rd_req_q;

    // Read FSM next state; a last-nibble edge falls through to loading the next word
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        nib_idx_n   = nib_idx;
        rd_nibble_n = rd_nibble;
        rd_valid_n  = rd_valid;
        pop         = 1'b0;

        if (rd_edge) begin
            if (state == R_SEND && nib_idx != '0) begin
                shreg_n     = shreg << 4;
                rd_nibble_n = shreg_n[ISI_W-1 -: 4];
                nib_idx_n   = nib_idx - 1'b1;
            end else if (!fifo_empty) begin
                pop         = 1'b1;
                shreg_n     = head;
                rd_nibble_n = head[ISI_W-1 -: 4];
                rd_valid_n  = 1'b1;
                nib_idx_n   = IDX_W'(NIB - 1);
                state_n     = R_SEND;
            end else if (state == R_SEND) begin
                rd_nibble_n = '0;
                rd_valid_n  = 1'b0;
                state_n     = R_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_adex_spike_monitor.sv
// Directed bench for adex_spike_monitor: ISI capture, saturation, FIFO overflow, windowed rate,
// enable handling and reset during readout.
module tb_adex_spike_monitor;

    localparam int unsigned ISI_W      = 12;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned WIN_W      = 16;
    localparam int unsigned CNT_W      = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             step_valid = 1'b0;
    logic             spike_in = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             rd_req = 1'b0;
    logic [3:0]       rd_nibble;
    logic             rd_valid;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow;
    logic [CNT_W-1:0] rate_count;
    logic             win_done;

    int n_checks = 0;
    int n_fail   = 0;

    adex_spike_monitor #(
        .ISI_W      (ISI_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIN_W      (WIN_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .step_valid (step_valid),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .rd_req     (rd_req),
        .rd_nibble  (rd_nibble),
        .rd_valid   (rd_valid),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .rate_count (rate_count),
        .win_done   (win_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic spk);
        step_valid = 1'b1;
        spike_in   = spk;
        tick();
        step_valid = 1'b0;
        spike_in   = 1'b0;
    endtask

    // n-1 quiet steps then a spike: pushes an ISI of n
    task automatic gap(input int n);
        repeat (n - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic rd_pulse();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic read_word(output logic [ISI_W-1:0] w);
        w = '0;
        repeat (ISI_W / 4) begin
            rd_pulse();
            w = {w[ISI_W-5:0], rd_nibble};
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        step_valid = 1'b0;
        spike_in   = 1'b0;
        rd_req     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ISI_W-1:0] w;
        logic [3:0]       exp_nib [6];

        // T1: reset values and basic ISI capture/readout
        enable = 1'b1;
        do_reset();
        check("rst_rd_nibble", 32'(rd_nibble), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'h1);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_rate_count", 32'(rate_count), 32'h0);
        check("rst_win_done", 32'(win_done), 32'h0);

        for (int i = 0; i <= 18; i++) step(i == 5 || i == 15 || i == 18);
        check("t1_not_empty", 32'(fifo_empty), 32'h0);
        exp_nib = '{4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 4'h3};
        for (int i = 0; i < 6; i++) begin
            rd_pulse();
            check($sformatf("t1_nib%0d", i), 32'(rd_nibble), 32'(exp_nib[i]));
            check($sformatf("t1_valid%0d", i), 32'(rd_valid), 32'h1);
        end
        rd_pulse();
        check("t1_end_valid", 32'(rd_valid), 32'h0);
        check("t1_end_empty", 32'(fifo_empty), 32'h1);
        check("t1_end_nibble", 32'(rd_nibble), 32'h0);

        // T2: ISI saturation
        do_reset();
        step(1'b1);
        repeat (4999) step(1'b0);
        step(1'b1);
        read_word(w);
        check("t2_sat_word", 32'(w), 32'hFFF);

        // T3: overflow, then push+pop while full
        do_reset();
        step(1'b1);
        for (int g = 2; g <= 7; g++) gap(g);
        check("t3_full", 32'(fifo_full), 32'h1);
        check("t3_overflow", 32'(overflow), 32'h1);
        check("t3_not_empty", 32'(fifo_empty), 32'h0);
        repeat (7) step(1'b0);
        step_valid = 1'b1;
        spike_in   = 1'b1;
        rd_req     = 1'b1;
        tick();
        step_valid = 1'b0;
        spike_in   = 1'b0;
        rd_req     = 1'b0;
        tick();
        check("t3_pp_valid", 32'(rd_valid), 32'h1);
        check("t3_pp_nib0", 32'(rd_nibble), 32'h0);
        check("t3_pp_full", 32'(fifo_full), 32'h1);
        rd_pulse();
        check("t3_w2_nib1", 32'(rd_nibble), 32'h0);
        rd_pulse();
        check("t3_w2_nib2", 32'(rd_nibble), 32'h2);
        read_word(w);
        check("t3_w3", 32'(w), 32'h3);
        read_word(w);
        check("t3_w4", 32'(w), 32'h4);
        read_word(w);
        check("t3_w5", 32'(w), 32'h5);
        read_word(w);
        check("t3_w8", 32'(w), 32'h8);
        rd_pulse();
        check("t3_end_valid", 32'(rd_valid), 32'h0);
        check("t3_end_empty", 32'(fifo_empty), 32'h1);
        check("t3_overflow_sticky", 32'(overflow), 32'h1);

        // T4: windowed rate
        do_reset();
        win_len = 16'd100;
        for (int i = 0; i <= 98; i++)
            step(i == 3 || i == 10 || i == 20 || i == 40 || i == 60 || i == 80);
        check("t4_pre_done", 32'(win_done), 32'h0);
        check("t4_pre_rate", 32'(rate_count), 32'h0);
        step(1'b1);
        check("t4_done", 32'(win_done), 32'h1);
        check("t4_rate", 32'(rate_count), 32'h7);
        tick();
        check("t4_done_pulse", 32'(win_done), 32'h0);
        for (int i = 0; i <= 99; i++) begin
            step(i == 0 || i == 50);
            if (i == 50) check("t4_rate_hold", 32'(rate_count), 32'h7);
        end
        check("t4_rate2", 32'(rate_count), 32'h2);

        // T5: held spike level counts once; enable low clears first_seen
        do_reset();
        win_len  = 16'd3;
        spike_in = 1'b1;
        tick();
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        tick();
        tick();
        spike_in = 1'b0;
        step(1'b0);
        step(1'b0);
        check("t5_rate_once", 32'(rate_count), 32'h1);
        check("t5_no_push", 32'(fifo_empty), 32'h1);
        enable = 1'b0;
        tick();
        step(1'b1);
        tick();
        check("t5_rate_kept", 32'(rate_count), 32'h1);
        enable = 1'b1;
        step(1'b1);
        check("t5_reenable_no_push", 32'(fifo_empty), 32'h1);
        gap(4);
        read_word(w);
        check("t5_isi", 32'(w), 32'h4);

        // T6: reset during readout
        do_reset();
        win_len = 16'd2;
        step(1'b1);
        for (int g = 2; g <= 7; g++) gap(g);
        check("t6_pre_overflow", 32'(overflow), 32'h1);
        check("t6_pre_rate", 32'(rate_count), 32'h1);
        rd_pulse();
        check("t6_pre_valid", 32'(rd_valid), 32'h1);
        do_reset();
        check("t6_valid", 32'(rd_valid), 32'h0);
        check("t6_empty", 32'(fifo_empty), 32'h1);
        check("t6_full", 32'(fifo_full), 32'h0);
        check("t6_overflow", 32'(overflow), 32'h0);
        check("t6_rate", 32'(rate_count), 32'h0);
        check("t6_nibble", 32'(rd_nibble), 32'h0);
        rd_pulse();
        check("t6_read_empty", 32'(rd_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
